// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl
// Memory-stage load/store responder. A single-cycle LW/SW request from the
// decoder becomes a req/ack transaction on the data-memory bus. The pipeline
// is stalled until the transaction completes. Misaligned and contradictory
// requests are turned into an exception pulse without touching the bus.
//
// Optional feature macro: DMEM_TIMEOUT_EN
//   When defined, a REQ that sees no ack for TIMEOUT_CYC cycles is abandoned
//   and reported with exc_cause 11. When undefined, REQ waits indefinitely.
module dmem_access_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              stall,
  output logic [DATA_W-1:0] rdata,
  output logic              rd_valid,
  output logic              exc,
  output logic [1:0]        exc_cause,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_CONFLICT = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

  state_t     state;
  state_t     next_state;
  logic [1:0] pend_cause;
  logic       pend_rd;

  logic req_any;
  logic conflict;
  logic misaligned;
  logic legal;
  logic timeout_hit;

  assign req_any    = mem_read | mem_write;
  assign conflict   = mem_read & mem_write;
  assign misaligned = (addr[1:0] != 2'b00);
  assign legal      = req_any & ~conflict & ~misaligned;

`ifdef DMEM_TIMEOUT_EN
  localparam int                CNT_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] wait_cnt;

  // Counts REQ cycles without ack; held at zero outside REQ so every entry starts clean
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (state != REQ) begin
      wait_cnt <= '0;
    end else if (!bus_ack) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  assign timeout_hit = (state == REQ) && !bus_ack && (wait_cnt == CNT_LAST);
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
  assign timeout_hit        = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode and the combinational handshake/status outputs
  always_comb begin
    next_state = state;
    stall      = 1'b0;
    bus_req    = 1'b0;
    rd_valid   = 1'b0;
    exc        = 1'b0;
    exc_cause  = CAUSE_NONE;
    unique case (state)
      IDLE: begin
        stall = req_any;
        if (legal) begin
          next_state = REQ;
        end else if (req_any) begin
          next_state = DONE;
        end
      end
      REQ: begin
        stall   = 1'b1;
        bus_req = 1'b1;
        if (bus_ack || timeout_hit) begin
          next_state = DONE;
        end
      end
      DONE: begin
        rd_valid   = pend_rd;
        exc        = (pend_cause != CAUSE_NONE);
        exc_cause  = pend_cause;
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Bus request registers, pending result flags and the load-data register
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
      rdata      <= '0;
      pend_cause <= CAUSE_NONE;
      pend_rd    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          pend_rd <= 1'b0;
          if (legal) begin
            bus_we     <= mem_write;
            bus_addr   <= {addr[ADDR_W-1:2], 2'b00};
            bus_wdata  <= wdata;
            pend_cause <= CAUSE_NONE;
          end else if (conflict) begin
            pend_cause <= CAUSE_CONFLICT;
          end else if (req_any) begin
            pend_cause <= CAUSE_MISALIGN;
          end else begin
            pend_cause <= CAUSE_NONE;
          end
        end
        REQ: begin
          if (bus_ack) begin
            if (!bus_we) begin
              rdata   <= bus_rdata;
              pend_rd <= 1'b1;
            end
          end else if (timeout_hit) begin
            pend_cause <= CAUSE_TIMEOUT;
          end
        end
        DONE: begin
          pend_cause <= CAUSE_NONE;
          pend_rd    <= 1'b0;
        end
        default: begin
          pend_cause <= CAUSE_NONE;
          pend_rd    <= 1'b0;
        end
      endcase
    end
  end

endmodule
